// File: rtl/gpio_bank_arbiter.sv
// gpio_bank_arbiter
//   Two requesters share one bank of GPIO pins. Ownership is arbitrated
//   round-robin. Release or forced revocation passes through a one-cycle
//   turnaround with the pads tri-stated. A timeout revokes a grant that is
//   held too long while the other requester waits. The revoked requester is
//   then masked until it drops its request.
//
// Ports
//   clock          : single clock for all logic
//   reset          : asynchronous active-high reset
//   req0/req1      : ownership requests
//   gnt0/gnt1      : registered ownership grants (never both high)
//   oe0/oe1        : requester output-enables
//   out0/out1      : requester output values
//   gpio_oe        : registered output-enable to the pad layer
//   gpio_output    : registered output value to the pad layer
//   gpio_input     : pad readback
//   gpio_rdata     : gpio_input forwarded combinationally to both requesters
//   timeout_pulse  : one-cycle pulse on forced revocation
module gpio_bank_arbiter #(
  parameter int GPIO_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic [GPIO_WIDTH-1:0] oe0,
  input  logic [GPIO_WIDTH-1:0] oe1,
  input  logic [GPIO_WIDTH-1:0] out0,
  input  logic [GPIO_WIDTH-1:0] out1,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic [GPIO_WIDTH-1:0] gpio_output,
  input  logic [GPIO_WIDTH-1:0] gpio_input,
  output logic [GPIO_WIDTH-1:0] gpio_rdata,
  output logic                  timeout_pulse
);

  // A zero timeout still needs a one-bit counter so the vector is legal.
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LIMIT = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT0     = 2'd1,
    ST_GRANT1     = 2'd2,
    ST_TURNAROUND = 2'd3
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic                    last_owner_r, last_owner_nxt_s;
  logic                    mask0_r, mask0_nxt_s;
  logic                    mask1_r, mask1_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic [GPIO_WIDTH-1:0]   oe_nxt_s, out_nxt_s;
  logic                    pulse_nxt_s;
  logic                    req0_eff_s, req1_eff_s;
  logic                    expire0_s, expire1_s;

  // Pad readback is shared by both requesters with no register stage.
  assign gpio_rdata = gpio_input;

  // A masked requester is invisible to arbitration in IDLE.
  assign req0_eff_s = req0 & ~mask0_r;
  assign req1_eff_s = req1 & ~mask1_r;

  // Timeout expiry: the waiting requester is still asserted at the last count.
  assign expire0_s = TO_EN && req1 && (cnt_r == TO_LIMIT);
  assign expire1_s = TO_EN && req0 && (cnt_r == TO_LIMIT);

  // Next-state, counter, mask and pad value computation.
  always_comb begin
    state_nxt_s      = state_r;
    last_owner_nxt_s = last_owner_r;
    cnt_nxt_s        = cnt_r;
    oe_nxt_s         = {GPIO_WIDTH{1'b0}};
    out_nxt_s        = {GPIO_WIDTH{1'b0}};
    pulse_nxt_s      = 1'b0;
    // Any sampled low request clears that requester's mask.
    mask0_nxt_s      = mask0_r & req0;
    mask1_nxt_s      = mask1_r & req1;

    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (req0_eff_s && req1_eff_s) begin
          // Contested: the requester that did not own the bank last wins.
          if (last_owner_r) begin
            state_nxt_s      = ST_GRANT0;
            last_owner_nxt_s = 1'b0;
          end else begin
            state_nxt_s      = ST_GRANT1;
            last_owner_nxt_s = 1'b1;
          end
        end else if (req0_eff_s) begin
          state_nxt_s      = ST_GRANT0;
          last_owner_nxt_s = 1'b0;
        end else if (req1_eff_s) begin
          state_nxt_s      = ST_GRANT1;
          last_owner_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_GRANT0: begin
        if (!req0) begin
          // Release wins over a simultaneous timeout.
          state_nxt_s = ST_TURNAROUND;
        end else if (expire0_s) begin
          state_nxt_s = ST_TURNAROUND;
          pulse_nxt_s = 1'b1;
          mask0_nxt_s = 1'b1;
        end else begin
          oe_nxt_s  = oe0;
          out_nxt_s = out0;
          if (req1 && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
      end

      ST_GRANT1: begin
        if (!req1) begin
          state_nxt_s = ST_TURNAROUND;
        end else if (expire1_s) begin
          state_nxt_s = ST_TURNAROUND;
          pulse_nxt_s = 1'b1;
          mask1_nxt_s = 1'b1;
        end else begin
          oe_nxt_s  = oe1;
          out_nxt_s = out1;
          if (req0 && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
      end

      ST_TURNAROUND: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end

      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, grant, pad and timeout registers; reset tri-states the pads at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      last_owner_r  <= 1'b1;
      mask0_r       <= 1'b0;
      mask1_r       <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      gpio_oe       <= {GPIO_WIDTH{1'b0}};
      gpio_output   <= {GPIO_WIDTH{1'b0}};
      timeout_pulse <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      last_owner_r  <= last_owner_nxt_s;
      mask0_r       <= mask0_nxt_s;
      mask1_r       <= mask1_nxt_s;
      cnt_r         <= cnt_nxt_s;
      gnt0          <= (state_nxt_s == ST_GRANT0);
      gnt1          <= (state_nxt_s == ST_GRANT1);
      gpio_oe       <= oe_nxt_s;
      gpio_output   <= out_nxt_s;
      timeout_pulse <= pulse_nxt_s;
    end
  end

endmodule

// File: tb/tb_gpio_bank_arbiter.sv
// Bench for gpio_bank_arbiter: two instances (timeout 8 and timeout 0)
// share the stimulus and are compared against a behavioural model of
// ownership, waiting time and masks.
module tb_gpio_bank_arbiter;
  localparam int W = 3;
  localparam int VW = 2*W + 3;

  logic clock;
  logic reset;
  logic req0, req1;
  logic [W-1:0] oe0, oe1, out0, out1, gpio_input;

  logic gnt0_a, gnt1_a, timeout_pulse_a;
  logic [W-1:0] gpio_oe_a, gpio_output_a, gpio_rdata_a;
  logic gnt0_b, gnt1_b, timeout_pulse_b;
  logic [W-1:0] gpio_oe_b, gpio_output_b, gpio_rdata_b;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_bank_arbiter #(.GPIO_WIDTH(W), .TIMEOUT_CYCLES(8)) u_dut_a (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .oe0(oe0), .oe1(oe1), .out0(out0), .out1(out1),
    .gpio_oe(gpio_oe_a), .gpio_output(gpio_output_a), .gpio_input(gpio_input),
    .gpio_rdata(gpio_rdata_a), .timeout_pulse(timeout_pulse_a));

  gpio_bank_arbiter #(.GPIO_WIDTH(W), .TIMEOUT_CYCLES(0)) u_dut_b (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .oe0(oe0), .oe1(oe1), .out0(out0), .out1(out1),
    .gpio_oe(gpio_oe_b), .gpio_output(gpio_output_b), .gpio_input(gpio_input),
    .gpio_rdata(gpio_rdata_b), .timeout_pulse(timeout_pulse_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  a_mutex: assert property (@(negedge clock) !(gnt0_a && gnt1_a) && !(gnt0_b && gnt1_b))
    else $error("grants both high");

  wire [VW-1:0] obs_a = {gnt0_a, gnt1_a, timeout_pulse_a, gpio_oe_a, gpio_output_a};
  wire [VW-1:0] obs_b = {gnt0_b, gnt1_b, timeout_pulse_b, gpio_oe_b, gpio_output_b};

  // Reference model: index 0 models timeout 8, index 1 timeout 0.
  int       tos [2] = '{8, 0};
  int       m_owner [2];   // -1: nobody owns the bank
  int       m_cool [2];    // 1: in the dead cycle after a release
  int       m_wait [2];    // cycles the other requester has waited
  int       m_last [2];
  bit       m_mask [2][2];
  logic [W-1:0] m_oe [2];
  logic [W-1:0] m_out [2];
  bit       m_pulse [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_cool[k] = 0; m_wait[k] = 0; m_last[k] = 1;
      m_mask[k][0] = 1'b0; m_mask[k][1] = 1'b0;
      m_oe[k] = '0; m_out[k] = '0; m_pulse[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit r [2];
    bit om [2];
    logic [W-1:0] ov [2];
    logic [W-1:0] dv [2];
    int o, p, win;
    r[0] = req0; r[1] = req1;
    ov[0] = oe0; ov[1] = oe1; dv[0] = out0; dv[1] = out1;
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 1'b0; m_oe[k] = '0; m_out[k] = '0;
      for (int i = 0; i < 2; i++) begin
        om[i] = m_mask[k][i];
        if (!r[i]) m_mask[k][i] = 1'b0;
      end
      if (m_cool[k] == 1) begin
        m_cool[k] = 0;
      end else if (m_owner[k] < 0) begin
        win = -1;
        if (r[0] && !om[0] && r[1] && !om[1]) win = 1 - m_last[k];
        else if (r[0] && !om[0]) win = 0;
        else if (r[1] && !om[1]) win = 1;
        if (win >= 0) begin
          m_owner[k] = win; m_last[k] = win; m_wait[k] = 0;
        end
      end else begin
        o = m_owner[k]; p = 1 - o;
        if (!r[o]) begin
          m_owner[k] = -1; m_cool[k] = 1;
        end else if (tos[k] > 0 && r[p] && m_wait[k] == tos[k] - 1) begin
          m_owner[k] = -1; m_cool[k] = 1; m_pulse[k] = 1'b1; m_mask[k][o] = 1'b1;
        end else begin
          m_oe[k] = ov[o]; m_out[k] = dv[o];
          if (r[p]) m_wait[k]++;
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec(int k);
    return {m_owner[k] == 0, m_owner[k] == 1, m_pulse[k], m_oe[k], m_out[k]};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; model_reset();
    req0 = 1'b0; req1 = 1'b0; oe0 = '0; oe1 = '0; out0 = '0; out1 = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({obs_a, obs_b} !== '0) begin
      n_bad++; $display("FAIL reset_state: got %b/%b expected all zero", obs_a, obs_b);
    end
    gpio_input = 3'b110; #1;
    n_cmp++;
    if (gpio_rdata_a !== 3'b110 || gpio_rdata_b !== 3'b110) begin
      n_bad++; $display("FAIL rdata: got %b/%b expected 110", gpio_rdata_a, gpio_rdata_b);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (obs_a !== exp_vec(0) || obs_a !== '0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b expected %b", obs_a, exp_vec(0));
    end
  endtask

  task automatic test_single_grant();
    do_reset();
    req0 = 1'b1; oe0 = 3'b101; out0 = 3'b100;
    tick();
    n_cmp++;
    if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0 || gpio_oe_a !== 3'b000) begin
      n_bad++; $display("FAIL grant_latency: got gnt0=%b gnt1=%b oe=%b expected 1 0 000", gnt0_a, gnt1_a, gpio_oe_a);
    end
    tick();
    n_cmp++;
    if (gpio_oe_a !== 3'b101 || gpio_output_a !== 3'b100 || obs_b !== exp_vec(1)) begin
      n_bad++; $display("FAIL pad_follow: got oe=%b out=%b expected 101 100", gpio_oe_a, gpio_output_a);
    end
    req0 = 1'b0;
    tick();
    n_cmp++;
    if (gnt0_a !== 1'b0 || gpio_oe_a !== 3'b000 || gpio_output_a !== 3'b000) begin
      n_bad++; $display("FAIL release: got gnt0=%b oe=%b out=%b expected 0 000 000", gnt0_a, gpio_oe_a, gpio_output_a);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0 = 1'b1; req1 = 1'b1; oe0 = 3'b011; oe1 = 3'b110; out0 = 3'b001; out1 = 3'b010;
    tick();
    n_cmp++;
    if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0) begin
      n_bad++; $display("FAIL first_contest: got gnt0=%b gnt1=%b expected 1 0", gnt0_a, gnt1_a);
    end
    req0 = 1'b0;
    tick();
    n_cmp++;
    if (gnt0_a !== 1'b0 || gnt1_a !== 1'b0 || gpio_oe_a !== 3'b000) begin
      n_bad++; $display("FAIL turnaround: got gnt=%b%b oe=%b expected 00 000", gnt0_a, gnt1_a, gpio_oe_a);
    end
    tick();
    n_cmp++;
    if (gnt1_a !== 1'b0 || gpio_oe_a !== 3'b000) begin
      n_bad++; $display("FAIL turnaround_len: got gnt1=%b oe=%b expected 0 000", gnt1_a, gpio_oe_a);
    end
    tick();
    n_cmp++;
    if (gnt1_a !== 1'b1 || gnt0_a !== 1'b0 || obs_b !== exp_vec(1)) begin
      n_bad++; $display("FAIL regrant: got gnt0=%b gnt1=%b expected 0 1", gnt0_a, gnt1_a);
    end
    req1 = 1'b0;
    tick(); tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    n_cmp++;
    if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0) begin
      n_bad++; $display("FAIL second_contest: got gnt0=%b gnt1=%b expected 1 0", gnt0_a, gnt1_a);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req0 = 1'b1; oe0 = 3'b111; out0 = 3'b101;
    tick();
    req1 = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_cmp++;
      if (gnt0_a !== 1'b1 || timeout_pulse_a !== 1'b0) begin
        n_bad++; $display("FAIL hold_wait%0d: got gnt0=%b pulse=%b expected 1 0", i, gnt0_a, timeout_pulse_a);
      end
    end
    tick();
    n_cmp++;
    if (gnt0_a !== 1'b0 || timeout_pulse_a !== 1'b1 || gpio_oe_a !== 3'b000) begin
      n_bad++; $display("FAIL revoke: got gnt0=%b pulse=%b oe=%b expected 0 1 000", gnt0_a, timeout_pulse_a, gpio_oe_a);
    end
    n_cmp++;
    if (gnt0_b !== 1'b1 || timeout_pulse_b !== 1'b0) begin
      n_bad++; $display("FAIL no_timeout_inst: got gnt0=%b pulse=%b expected 1 0", gnt0_b, timeout_pulse_b);
    end
    tick();
    n_cmp++;
    if (timeout_pulse_a !== 1'b0 || gnt1_a !== 1'b0) begin
      n_bad++; $display("FAIL pulse_width: got pulse=%b gnt1=%b expected 0 0", timeout_pulse_a, gnt1_a);
    end
    tick();
    n_cmp++;
    if (gnt1_a !== 1'b1) begin
      n_bad++; $display("FAIL grant_after_revoke: got gnt1=%b expected 1", gnt1_a);
    end
    req1 = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (gnt0_a !== 1'b0 || obs_a !== exp_vec(0)) begin
      n_bad++; $display("FAIL mask_hold: got gnt0=%b expected 0", gnt0_a);
    end
    req0 = 1'b0; tick();
    req0 = 1'b1; tick();
    n_cmp++;
    if (gnt0_a !== 1'b1) begin
      n_bad++; $display("FAIL mask_clear: got gnt0=%b expected 1", gnt0_a);
    end
  endtask

  task automatic test_release_at_timeout();
    do_reset();
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    req0 = 1'b0;
    tick();
    n_cmp++;
    if (timeout_pulse_a !== 1'b0 || gnt0_a !== 1'b0) begin
      n_bad++; $display("FAIL release_wins: got pulse=%b gnt0=%b expected 0 0", timeout_pulse_a, gnt0_a);
    end
    req0 = 1'b1; req1 = 1'b0;
    tick(); tick();
    n_cmp++;
    if (gnt0_a !== 1'b1) begin
      n_bad++; $display("FAIL not_masked: got gnt0=%b expected 1", gnt0_a);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req1 = 1'b1; oe1 = 3'b111; out1 = 3'b011;
    tick(); tick();
    n_cmp++;
    if (gnt1_a !== 1'b1 || gpio_oe_a !== 3'b111 || gpio_output_a !== 3'b011) begin
      n_bad++; $display("FAIL pre_reset: got gnt1=%b oe=%b out=%b expected 1 111 011", gnt1_a, gpio_oe_a, gpio_output_a);
    end
    #2 reset = 1'b1; model_reset();
    #1;
    n_cmp++;
    if (gnt1_a !== 1'b0 || gpio_oe_a !== 3'b000 || gpio_output_a !== 3'b000 || gnt1_b !== 1'b0 || gpio_oe_b !== 3'b000) begin
      n_bad++; $display("FAIL async_reset: got gnt1=%b oe=%b/%b expected 0 000", gnt1_a, gpio_oe_a, gpio_oe_b);
    end
    #1 reset = 1'b0;
    tick();
    n_cmp++;
    if (gnt1_a !== 1'b1 || gpio_oe_a !== 3'b000) begin
      n_bad++; $display("FAIL idle_after_async: got gnt1=%b oe=%b expected 1 000", gnt1_a, gpio_oe_a);
    end
  endtask

  task automatic test_no_timeout();
    do_reset();
    req0 = 1'b1;
    tick();
    req1 = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      oe0 = W'($urandom); out0 = W'($urandom);
      tick();
      n_cmp++;
      if (gnt0_b !== 1'b1 || timeout_pulse_b !== 1'b0 || obs_b !== exp_vec(1) || (gnt0_b && gnt1_b)) begin
        n_bad++; $display("FAIL long_wait@%0d: got %b expected %b", i, obs_b, exp_vec(1));
      end
      n_cmp++;
      if (obs_a !== exp_vec(0)) begin
        n_bad++; $display("FAIL long_wait_t8@%0d: got %b expected %b", i, obs_a, exp_vec(0));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req0 = ~req0;
      if ($urandom_range(7) == 0) req1 = ~req1;
      oe0 = W'($urandom); oe1 = W'($urandom);
      out0 = W'($urandom); out1 = W'($urandom);
      gpio_input = W'($urandom);
      if ($urandom_range(499) == 0) begin
        #2 reset = 1'b1; model_reset();
        #1 reset = 1'b0;
      end
      tick();
      n_cmp++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        n_bad++; $display("FAIL random@%0d: got %b/%b expected %b/%b", i, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      n_cmp++;
      if (gpio_rdata_a !== gpio_input || gpio_rdata_b !== gpio_input) begin
        n_bad++; $display("FAIL random_rdata@%0d: got %b expected %b", i, gpio_rdata_a, gpio_input);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    oe0 = '0; oe1 = '0; out0 = '0; out1 = '0; gpio_input = '0;
    model_reset();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_timeout();
    test_release_at_timeout();
    test_async_reset();
    test_no_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
